multi_pattern_scanner: RTL and testbench
========================================

Name: multi_pattern_scanner

Overview:
Parametrised byte-stream scanner. Matches a configurable set of runtime-programmable fixed-length patterns against each input stream. Match records stream out through a result FIFO while scanning continues, and each stream closes with an end-of-stream record. It sits between the byte deframer and the SID/offset result collector, using the same valid/ready/end conventions on both sides.

Parameters:
NUM_PATTERNS, 8, number of pattern slots (1..31).
PATTERN_BYTES, 4, pattern length in bytes (2..8).
FIFO_DEPTH, 8, result FIFO entries (power of 2, at least 2).

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
iEn  in  1  match enable; when low, no records are pushed
iChar  in  8  input byte
iValid  in  1  input byte valid
oReady  out  1  scanner accepts a byte
iEnd  in  1  marks the last byte of a stream (qualified by iValid&&oReady)
cfg_we  in  1  pattern slot write strobe
cfg_idx  in  $clog2(NUM_PATTERNS)  slot index; out-of-range writes are ignored
cfg_pattern  in  8*PATTERN_BYTES  pattern, first byte in MSBs
cfg_en  in  1  slot enable written with the pattern
iReady  in  1  downstream accepts a record
oSID  out  32  match bitmap [NUM_PATTERNS-1:0], zero-extended; bit31 = overflow (end record only)
oOffset  out  32  match record: stream offset of the last matched byte; end record: stream length in bytes
oValid  out  1  record valid
oEnd  out  1  record is the end-of-stream record
oOverflow  out  1  sticky: at least one match was dropped in the current stream

Behaviour:
- Reset values: oReady=0 during reset, oValid=0, oEnd=0, oSID=0, oOffset=0, oOverflow=0. Also cleared: all slots (pattern 0, disabled), FIFO, window, counters. State = SCAN.
- Accept: a byte is taken when iValid&&oReady. oReady=1 only in SCAN. There is no backpressure from the FIFO.
- Window: shift register of the last PATTERN_BYTES bytes. fill counter saturates at PATTERN_BYTES. Slot k matches only when fill==PATTERN_BYTES, slot k is enabled, and the window equals slot k.
- Offset counter: 32 bits, 0 for the first byte of a stream, +1 per accepted byte, wraps modulo 2^32. The window, fill and offset all clear after an accepted iEnd byte, so matches never span streams.
- Pipeline:
  - Byte accepted at cycle T.
  - Match bitmap and offset are registered at T+1.
  - If the bitmap is nonzero and iEn was high at T, the record is pushed at T+1.
  - The FIFO is first-word-fall-through, so oValid rises at T+2 when the FIFO was empty.
- Records: one record per byte with a nonzero bitmap. Simultaneous matches share one record; they are OR'd into the bitmap.
- FIFO full: a push with no same-cycle pop drops the record and sets oOverflow. A push with a same-cycle pop is accepted.
- Pop: the head entry is removed when oValid&&iReady and the head is not the end record.
- FSM:
  - SCAN -> DRAIN when the iEnd byte is accepted.
  - DRAIN: oReady=0. Wait until the pending pipeline record has been pushed and the FIFO is empty.
  - Then present the end record: oValid=1, oEnd=1, oSID={oOverflow,31'b0}, oOffset=stream length.
  - When the end record is accepted (oValid&&iReady): return to SCAN and clear oOverflow.
- iEn low: offset and window still advance; only pushes are suppressed.
- Config: a write takes effect on the next cycle and is legal in any state. A write in cycle T+1 does not alter the record already registered for byte T.
- Empty stream: not possible, since iEnd always accompanies a byte. A single-byte stream gives an end record with oOffset=1.
- Reset mid-stream or mid-drain: everything returns to reset values; partial records are discarded.

Decomposition:
- Package scanner_pkg: FSM state enum (SCAN, DRAIN), result record struct {bitmap[31:0], offset[31:0]}, overflow bit position constant.
- Sub-module scanner_result_fifo: synchronous first-word-fall-through FIFO with push/pop/full/empty, parametrised by width and FIFO_DEPTH.

Test Plan:
- Slot0=0a0b0c0d enabled; stream 11 0a 0b 0c 0d 22, iEnd on 22, iReady=1 -> record SID=0x1, Offset=4, oEnd=0. Then end record SID=0, Offset=6, oEnd=1.
- Slot1=aaaaaaaa; stream of 6 bytes aa -> records SID=0x2 at Offsets 3, 4, 5, then end record Offset=6.
- Slot2 and slot5 both =01020304; stream 01 02 03 04 -> single record SID=0x24, Offset=3.
- FIFO_DEPTH=8; iReady=0 while 10 matches occur -> oOverflow=1. Then iReady=1 -> exactly 8 records, then end record SID=0x80000000. oOverflow=0 after the end record is accepted.
- Stream A ends 0a 0b, stream B begins 0c 0d (slot0=0a0b0c0d) -> no match record. Stream B end record reports its own length.
- Reset asserted in DRAIN with 3 queued records -> next cycle oValid=0, oReady=1. A new stream 0a0b0c0d matches nothing, because all slots were cleared by reset.

Source files
------------

// File: rtl/scanner_pkg.sv
// Shared types for the multi-pattern byte scanner: FSM states and the result record layout.
package scanner_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] bitmap;
    logic [31:0] offset;
  } rec_t;

  localparam int REC_W   = 64;
  localparam int OVF_BIT = 31;

endpackage

// File: rtl/scanner_result_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO is only taken when a pop frees a slot the same cycle.
module scanner_result_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic              wr_en, rd_en;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + (AW+1)'(1);
      if (rd_en) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/multi_pattern_scanner.sv
// Byte-stream scanner matching runtime-programmable fixed-length patterns; emits match records and
// one end-of-stream record per stream through a FWFT result FIFO.
module multi_pattern_scanner
  import scanner_pkg::*;
#(
  parameter int NUM_PATTERNS  = 8,
  parameter int PATTERN_BYTES = 4,
  parameter int FIFO_DEPTH    = 8,
  localparam int IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  localparam int WIN_W = 8 * PATTERN_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iEn,
  input  logic [7:0]       iChar,
  input  logic             iValid,
  output logic             oReady,
  input  logic             iEnd,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIN_W-1:0] cfg_pattern,
  input  logic             cfg_en,
  input  logic             iReady,
  output logic [31:0]      oSID,
  output logic [31:0]      oOffset,
  output logic             oValid,
  output logic             oEnd,
  output logic             oOverflow
);

  localparam int FILL_W = $clog2(PATTERN_BYTES + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_BYTES);

  state_e                  state_q, state_d;
  logic [WIN_W-1:0]        pat_q [NUM_PATTERNS];
  logic [NUM_PATTERNS-1:0] en_q;
  logic [WIN_W-1:0]        win_q, win_shift;
  logic [FILL_W-1:0]       fill_q, fill_inc;
  logic [31:0]             off_q, len_q;
  logic [NUM_PATTERNS-1:0] match;
  logic                    accept;

  logic                    push_p1_q;
  logic [NUM_PATTERNS-1:0] bitmap_p1_q;
  logic [31:0]             offset_p1_q;

  rec_t                    push_rec, head;
  logic                    fifo_full, fifo_empty, pop, drop, end_rdy, ovf_q;

  assign oReady    = (state_q == SCAN) && !reset;
  assign accept    = iValid && oReady;
  assign win_shift = {win_q[WIN_W-9:0], iChar};
  assign fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

  // Match against the window as it looks with the incoming byte included.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_PATTERNS; k++) begin
      match[k] = (fill_inc == FILL_FULL) && en_q[k] && (win_shift == pat_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= '0;
      for (int k = 0; k < NUM_PATTERNS; k++) pat_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_PATTERNS; k++) begin
        if (cfg_we && (cfg_idx == IDX_W'(k))) begin
          pat_q[k] <= cfg_pattern;
          en_q[k]  <= cfg_en;
        end
      end
    end
  end

  // Stage 0: window, fill and offset advance per accepted byte; all restart after the end byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q  <= '0;
      fill_q <= '0;
      off_q  <= '0;
      len_q  <= '0;
    end else if (accept) begin
      if (iEnd) begin
        win_q  <= '0;
        fill_q <= '0;
        off_q  <= '0;
        len_q  <= off_q + 32'd1;
      end else begin
        win_q  <= win_shift;
        fill_q <= fill_inc;
        off_q  <= off_q + 32'd1;
      end
    end
  end

  // Stage 1: registered match record, pushed into the FIFO this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_p1_q   <= 1'b0;
      bitmap_p1_q <= '0;
      offset_p1_q <= '0;
    end else begin
      push_p1_q   <= accept && iEn && (|match);
      bitmap_p1_q <= match;
      offset_p1_q <= off_q;
    end
  end

  assign push_rec.bitmap = {{(32-NUM_PATTERNS){1'b0}}, bitmap_p1_q};
  assign push_rec.offset = offset_p1_q;

  scanner_result_fifo #(
    .DATA_W    (REC_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_p1_q),
    .data_i (push_rec),
    .pop_i  (pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // The end record is synthesised from state rather than queued, so it can never be dropped.
  assign end_rdy = (state_q == DRAIN) && !push_p1_q && fifo_empty;
  assign oValid  = !fifo_empty || end_rdy;
  assign pop     = oValid && iReady && !fifo_empty;
  assign drop    = push_p1_q && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (drop)                   ovf_q <= 1'b1;
      else if (end_rdy && iReady) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (accept && iEnd)   state_d = DRAIN;
      DRAIN:   if (end_rdy && iReady) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    oSID    = '0;
    oOffset = '0;
    oEnd    = 1'b0;
    if (!fifo_empty) begin
      oSID    = head.bitmap;
      oOffset = head.offset;
    end else if (end_rdy) begin
      oEnd          = 1'b1;
      oSID[OVF_BIT] = ovf_q;
      oOffset       = len_q;
    end
  end

  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_multi_pattern_scanner.sv
// Directed bench for multi_pattern_scanner: cycle table for basic streams plus sequences for overflow,
// stream boundaries, iEn gating and reset during drain.
module tb_multi_pattern_scanner;

  logic        clk = 1'b0;
  logic        reset, iEn, iValid, iEnd, cfg_we, cfg_en, iReady;
  logic [7:0]  iChar;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_pattern;
  logic        oReady, oValid, oEnd, oOverflow;
  logic [31:0] oSID, oOffset;

  int checks = 0;
  int failures = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] rec_sid_q[$];
  logic [31:0] rec_off_q[$];
  logic        got_end;
  logic [31:0] end_sid, end_off;

  typedef struct {
    logic        v;
    logic [7:0]  c;
    logic        e;
    logic        xrdy;
    logic        xov;
    logic        xend;
    logic [31:0] xsid;
    logic [31:0] xoff;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  multi_pattern_scanner #(
    .NUM_PATTERNS (8),
    .PATTERN_BYTES(4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iEn        (iEn),
    .iChar      (iChar),
    .iValid     (iValid),
    .oReady     (oReady),
    .iEnd       (iEnd),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_pattern(cfg_pattern),
    .cfg_en     (cfg_en),
    .iReady     (iReady),
    .oSID       (oSID),
    .oOffset    (oOffset),
    .oValid     (oValid),
    .oEnd       (oEnd),
    .oOverflow  (oOverflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] c, input logic e, input logic xrdy,
                              input logic xov, input logic xend, input logic [31:0] xsid,
                              input logic [31:0] xoff);
    vec_t r;
    r.v = v; r.c = c; r.e = e; r.xrdy = xrdy;
    r.xov = xov; r.xend = xend; r.xsid = xsid; r.xoff = xoff;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [31:0] pat, input logic en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_pattern = pat; cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic mon();
    if (oValid && iReady) begin
      if (oEnd) begin
        got_end = 1'b1; end_sid = oSID; end_off = oOffset;
      end else begin
        rec_sid_q.push_back(oSID); rec_off_q.push_back(oOffset);
      end
    end
  endtask

  task automatic start();
    rec_sid_q.delete(); rec_off_q.delete();
    got_end = 1'b0; end_sid = '0; end_off = '0;
  endtask

  task automatic send_bytes();
    for (int i = 0; i < stim_q.size(); i++) begin
      iValid = 1'b1; iChar = stim_q[i]; iEnd = (i == stim_q.size() - 1);
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
    end
    iValid = 1'b0; iEnd = 1'b0; iChar = 8'h00;
  endtask

  task automatic collect(input string name);
    int cyc = 0;
    while (!got_end && cyc < 60) begin
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      cyc++;
    end
    chk1({name, "_end_seen"}, got_end, 1'b1);
  endtask

  initial begin
    reset = 1'b1; iEn = 1'b1; iValid = 1'b0; iEnd = 1'b0; iChar = 8'h00; iReady = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_pattern = '0; cfg_en = 1'b0;
    start();

    repeat (2) tick();
    @(negedge clk);
    chk1("rst_oReady_low", oReady, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_oReady", oReady, 1'b1);
    chk1("rst_oValid", oValid, 1'b0);
    chk1("rst_oEnd", oEnd, 1'b0);
    chk("rst_oSID", oSID, 32'h0);
    chk("rst_oOffset", oOffset, 32'h0);
    chk1("rst_oOverflow", oOverflow, 1'b0);
    @(posedge clk); #1;

    cfg(3'd0, 32'h0a0b0c0d, 1'b1);
    cfg(3'd1, 32'haaaaaaaa, 1'b1);
    cfg(3'd2, 32'h01020304, 1'b1);
    cfg(3'd5, 32'h01020304, 1'b1);
    cfg(3'd3, 32'haaaaaaaa, 1'b0);

    // Stream 11 0a 0b 0c 0d 22
    tbl.push_back(mk(1, 8'h11, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h0a, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h0b, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h0c, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h0d, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h22, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h1, 32'd4));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 32'h0, 32'd6));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0));
    // Six aa bytes: overlapping matches on slot1 only (slot3 disabled)
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 8'haa, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'haa, 1, 1, 1, 0, 32'h2, 32'd3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h2, 32'd4));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h2, 32'd5));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 32'h0, 32'd6));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0));
    // 01 02 03 04 hits slots 2 and 5 together
    tbl.push_back(mk(1, 8'h01, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h03, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h04, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h24, 32'd3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 32'h0, 32'd4));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0));

    iReady = 1'b1; iEn = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      iValid = tbl[i].v; iChar = tbl[i].c; iEnd = tbl[i].e;
      @(negedge clk);
      chk1($sformatf("row%0d_oReady", i), oReady, tbl[i].xrdy);
      chk1($sformatf("row%0d_oValid", i), oValid, tbl[i].xov);
      if (tbl[i].xov) begin
        chk1($sformatf("row%0d_oEnd", i), oEnd, tbl[i].xend);
        chk($sformatf("row%0d_oSID", i), oSID, tbl[i].xsid);
        chk($sformatf("row%0d_oOffset", i), oOffset, tbl[i].xoff);
      end
      @(posedge clk); #1;
    end
    iValid = 1'b0; iEnd = 1'b0;

    // Overflow: 10 matches with downstream stalled, 8 fit
    start();
    stim_q.delete();
    repeat (13) stim_q.push_back(8'haa);
    iReady = 1'b0;
    send_bytes();
    repeat (4) tick();
    @(negedge clk);
    chk1("ovf_sticky", oOverflow, 1'b1);
    chk1("ovf_head_valid", oValid, 1'b1);
    chk1("ovf_head_not_end", oEnd, 1'b0);
    @(posedge clk); #1;
    iReady = 1'b1;
    collect("ovf");
    chk("ovf_nrec", 32'(rec_sid_q.size()), 32'd8);
    for (int i = 0; i < rec_sid_q.size(); i++) begin
      chk($sformatf("ovf_rec%0d_sid", i), rec_sid_q[i], 32'h2);
      chk($sformatf("ovf_rec%0d_off", i), rec_off_q[i], 32'(3 + i));
    end
    chk("ovf_end_sid", end_sid, 32'h8000_0000);
    chk("ovf_end_off", end_off, 32'd13);
    @(negedge clk);
    chk1("ovf_cleared", oOverflow, 1'b0);
    @(posedge clk); #1;

    // Match must not span streams
    start();
    stim_q = '{8'h0a, 8'h0b};
    send_bytes();
    collect("spanA");
    chk("spanA_nrec", 32'(rec_sid_q.size()), 32'd0);
    chk("spanA_end_off", end_off, 32'd2);
    start();
    stim_q = '{8'h0c, 8'h0d, 8'h0e};
    send_bytes();
    collect("spanB");
    chk("spanB_nrec", 32'(rec_sid_q.size()), 32'd0);
    chk("spanB_end_off", end_off, 32'd3);
    chk("spanB_end_sid", end_sid, 32'h0);

    // iEn low suppresses pushes only
    start();
    iEn = 1'b0;
    stim_q = '{8'h0a, 8'h0b, 8'h0c, 8'h0d};
    send_bytes();
    collect("noen");
    chk("noen_nrec", 32'(rec_sid_q.size()), 32'd0);
    chk("noen_end_off", end_off, 32'd4);
    iEn = 1'b1;

    // Single-byte stream
    start();
    stim_q = '{8'h55};
    send_bytes();
    collect("single");
    chk("single_end_off", end_off, 32'd1);

    // Reset while draining with 3 queued records
    start();
    stim_q.delete();
    repeat (6) stim_q.push_back(8'haa);
    iReady = 1'b0;
    send_bytes();
    repeat (3) tick();
    @(negedge clk);
    chk1("drain_valid_before_rst", oValid, 1'b1);
    chk1("drain_not_ready", oReady, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("post_rst_oValid", oValid, 1'b0);
    chk1("post_rst_oReady", oReady, 1'b1);
    chk1("post_rst_oOverflow", oOverflow, 1'b0);
    @(posedge clk); #1;
    start();
    iReady = 1'b1;
    stim_q = '{8'h0a, 8'h0b, 8'h0c, 8'h0d};
    send_bytes();
    collect("post_rst");
    chk("post_rst_nrec", 32'(rec_sid_q.size()), 32'd0);
    chk("post_rst_end_off", end_off, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
